// File: rtl/vga_snake_if.sv
// Scan-count / board-RAM / pixel bundle between the VGA counter,
// board RAM and the snake renderer.
interface vga_snake_if;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [1:0] cell_state;
  logic       game_over;
  logic [5:0] cell_x;
  logic [4:0] cell_y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       frame_tick;

  modport master (
    output h_count, v_count, cell_state, game_over,
    input  cell_x, cell_y, hsync, vsync, video_on,
    input  red, green, blue, frame_tick
  );

  modport slave (
    input  h_count, v_count, cell_state, game_over,
    output cell_x, cell_y, hsync, vsync, video_on,
    output red, green, blue, frame_tick
  );
endinterface

// File: rtl/vga_snake_render.sv
// 640x480 snake renderer: sync/blank decode, cell addressing,
// board RAM lookup and RGB332 output on an aligned 3-cycle pipe.
module vga_snake_render #(
  parameter int CELL_LOG2  = 4,
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int GRID_EN    = 0,
  parameter int FLASH_LOG2 = 4
) (
  input logic        i_clk_25mhz,
  input logic        i_rst,
  vga_snake_if.slave bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_END  = H_VISIBLE + H_FP + H_SYNC;
  localparam int VS_END  = V_VISIBLE + V_FP + V_SYNC;

  localparam logic [9:0] HV    = 10'(H_VISIBLE);
  localparam logic [9:0] VV    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] VS_LO = 10'(V_VISIBLE + V_FP);
  // sync window clipped to the line/frame length
  localparam logic [9:0] HS_HI =
    10'(((HS_END < H_TOTAL) ? HS_END : H_TOTAL) - 1);
  localparam logic [9:0] VS_HI =
    10'(((VS_END < V_TOTAL) ? VS_END : V_TOTAL) - 1);

  localparam logic [5:0] COL_LAST =
    6'((H_VISIBLE >> CELL_LOG2) - 1);
  localparam logic [4:0] ROW_LAST =
    5'((V_VISIBLE >> CELL_LOG2) - 1);
  localparam logic [9:0] PIX_MASK =
    10'((1 << CELL_LOG2) - 1);

  logic       w_vis;
  logic       w_hs;
  logic       w_vs;
  logic       w_ft;
  logic       w_wall;
  logic       w_grid;
  logic [5:0] w_cx;
  logic [4:0] w_cy;

  assign w_vis = (bus.h_count < HV) && (bus.v_count < VV);
  assign w_hs  = !((bus.h_count >= HS_LO) &&
                   (bus.h_count <= HS_HI));
  assign w_vs  = !((bus.v_count >= VS_LO) &&
                   (bus.v_count <= VS_HI));
  assign w_ft  = (bus.h_count == '0) && (bus.v_count == '0);

  assign w_cx = w_vis ? 6'(bus.h_count >> CELL_LOG2) : '0;
  assign w_cy = w_vis ? 5'(bus.v_count >> CELL_LOG2) : '0;

  assign w_wall = (w_cx == '0) || (w_cx == COL_LAST) ||
                  (w_cy == '0) || (w_cy == ROW_LAST);
  assign w_grid = (GRID_EN != 0) &&
                  (((bus.h_count & PIX_MASK) == '0) ||
                   ((bus.v_count & PIX_MASK) == '0));

  logic       r_s1_vis;
  logic       r_s1_hs;
  logic       r_s1_vs;
  logic       r_s1_ft;
  logic       r_s1_wall;
  logic       r_s1_grid;
  logic       r_s1_go;
  logic [5:0] r_cell_x;
  logic [4:0] r_cell_y;

  always_ff @(posedge i_clk_25mhz or posedge i_rst) begin
    if (i_rst) begin
      r_s1_vis  <= 1'b0;
      r_s1_hs   <= 1'b1;
      r_s1_vs   <= 1'b1;
      r_s1_ft   <= 1'b0;
      r_s1_wall <= 1'b0;
      r_s1_grid <= 1'b0;
      r_s1_go   <= 1'b0;
      r_cell_x  <= '0;
      r_cell_y  <= '0;
    end else begin
      r_s1_vis  <= w_vis;
      r_s1_hs   <= w_hs;
      r_s1_vs   <= w_vs;
      r_s1_ft   <= w_ft;
      r_s1_wall <= w_wall;
      r_s1_grid <= w_grid;
      r_s1_go   <= bus.game_over;
      r_cell_x  <= w_cx;
      r_cell_y  <= w_cy;
    end
  end

  logic r_s2_vis;
  logic r_s2_hs;
  logic r_s2_vs;
  logic r_s2_ft;
  logic r_s2_wall;
  logic r_s2_grid;
  logic r_s2_go;

  // flags wait here while the board RAM answers for r_cell_x/y
  always_ff @(posedge i_clk_25mhz or posedge i_rst) begin
    if (i_rst) begin
      r_s2_vis  <= 1'b0;
      r_s2_hs   <= 1'b1;
      r_s2_vs   <= 1'b1;
      r_s2_ft   <= 1'b0;
      r_s2_wall <= 1'b0;
      r_s2_grid <= 1'b0;
      r_s2_go   <= 1'b0;
    end else begin
      r_s2_vis  <= r_s1_vis;
      r_s2_hs   <= r_s1_hs;
      r_s2_vs   <= r_s1_vs;
      r_s2_ft   <= r_s1_ft;
      r_s2_wall <= r_s1_wall;
      r_s2_grid <= r_s1_grid;
      r_s2_go   <= r_s1_go;
    end
  end

  logic [7:0] r_frame_cnt;
  logic       w_flash_off;
  logic [7:0] w_cell_rgb;
  logic [7:0] w_rgb;

  assign w_flash_off = r_s2_go && r_frame_cnt[FLASH_LOG2];

  always_comb begin
    w_cell_rgb = 8'h00;
    case (bus.cell_state)
      2'b10:   w_cell_rgb = 8'hFC;
      2'b11:   w_cell_rgb = 8'hE0;
      2'b01:   w_cell_rgb = 8'h1C;
      default: w_cell_rgb = 8'h00;
    endcase
  end

  always_comb begin
    w_rgb = 8'h00;
    unique case (1'b1)
      !r_s2_vis:
        w_rgb = 8'h00;
      r_s2_vis && r_s2_wall:
        w_rgb = w_flash_off ? 8'h00 : 8'h92;
      r_s2_vis && !r_s2_wall && r_s2_grid:
        w_rgb = 8'h49;
      r_s2_vis && !r_s2_wall && !r_s2_grid:
        w_rgb = w_cell_rgb;
      default:
        w_rgb = 8'h00;
    endcase
  end

  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_frame_tick;
  logic [7:0] r_rgb;

  always_ff @(posedge i_clk_25mhz or posedge i_rst) begin
    if (i_rst) begin
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_video_on   <= 1'b0;
      r_frame_tick <= 1'b0;
      r_rgb        <= 8'h00;
      r_frame_cnt  <= 8'h00;
    end else begin
      r_hsync      <= r_s2_hs;
      r_vsync      <= r_s2_vs;
      r_video_on   <= r_s2_vis;
      r_frame_tick <= r_s2_ft;
      r_rgb        <= w_rgb;
      if (r_s2_ft)
        r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign bus.cell_x     = r_cell_x;
  assign bus.cell_y     = r_cell_y;
  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.video_on   = r_video_on;
  assign bus.frame_tick = r_frame_tick;
  assign bus.red        = r_rgb[7:5];
  assign bus.green      = r_rgb[4:2];
  assign bus.blue       = r_rgb[1:0];

endmodule

// File: tb/tb_vga_snake_render.sv
// Scoreboard bench for vga_snake_render: random and directed pixels
// checked against a pixel-rule model and a board RAM model.
module tb_vga_snake_render;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  vga_snake_if bus ();

  vga_snake_render dut (
    .i_clk_25mhz (clk),
    .i_rst       (rst),
    .bus         (bus)
  );

  typedef struct {
    int          e;
    int          h;
    int          v;
    logic [5:0]  cx;
    logic [4:0]  cy;
    logic [11:0] o;
    bit          sweep;
  } rec_t;

  rec_t qa[$];
  rec_t qo[$];

  logic [1:0] board [0:31][0:63];

  int ecnt    = 0;
  int tests   = 0;
  int fails   = 0;
  int fcnt    = 0;
  int hs_lows = 0;

  // synchronous-read board RAM
  initial begin
    bus.cell_state = 2'b00;
    forever begin
      @(posedge clk);
      bus.cell_state <= board[bus.cell_y][bus.cell_x];
    end
  end

  // monitor: address one edge after sampling, pixel three edges
  initial begin
    rec_t r;
    logic [11:0] act;
    forever begin
      @(posedge clk);
      ecnt++;
      #1;
      if (qa.size() > 0 && qa[0].e == ecnt) begin
        r = qa.pop_front();
        tests++;
        if (bus.cell_x !== r.cx || bus.cell_y !== r.cy) begin
          fails++;
          $display("FAIL addr h=%0d v=%0d got %0d,%0d exp %0d,%0d",
                   r.h, r.v, bus.cell_x, bus.cell_y, r.cx, r.cy);
        end
      end
      if (qo.size() > 0 && qo[0].e + 2 == ecnt) begin
        r = qo.pop_front();
        act = {bus.hsync, bus.vsync, bus.video_on,
               bus.frame_tick, bus.red, bus.green, bus.blue};
        if (r.sweep && bus.hsync === 1'b0)
          hs_lows++;
        tests++;
        if (act !== r.o) begin
          fails++;
          $display("FAIL pix h=%0d v=%0d got %h exp %h",
                   r.h, r.v, act, r.o);
        end
      end
    end
  end

  function automatic logic [7:0] cell_colour(logic [1:0] s);
    case (s)
      2'b10:   return 8'hFC;
      2'b11:   return 8'hE0;
      2'b01:   return 8'h1C;
      default: return 8'h00;
    endcase
  endfunction

  task automatic drive(int h, int v, bit go, bit sw);
    rec_t r;
    bit vis, hs, vs, ft, wall, dark;
    int cx, cy;
    logic [7:0] rgb;
    @(negedge clk);
    bus.h_count   = 10'(h);
    bus.v_count   = 10'(v);
    bus.game_over = go;
    vis  = (h < 640) && (v < 480);
    hs   = !(h >= 656 && h < 752);
    vs   = !(v >= 490 && v < 492);
    ft   = (h == 0) && (v == 0);
    cx   = vis ? h / 16 : 0;
    cy   = vis ? v / 16 : 0;
    wall = (cx == 0) || (cx == 39) || (cy == 0) || (cy == 29);
    // wall dark during every second block of 16 frames
    dark = go && ((fcnt % 32) >= 16);
    if (!vis)
      rgb = 8'h00;
    else if (wall)
      rgb = dark ? 8'h00 : 8'h92;
    else
      rgb = cell_colour(board[cy][cx]);
    r.e  = ecnt + 1;
    r.h  = h;
    r.v  = v;
    r.cx = 6'(cx);
    r.cy = 5'(cy);
    r.o  = {hs, vs, vis, ft, rgb};
    r.sweep = sw;
    qa.push_back(r);
    qo.push_back(r);
    if (ft)
      fcnt++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (qo.size() > 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (qo.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain timeout left %0d exp 0", qo.size());
      qa.delete();
      qo.delete();
    end
  endtask

  task automatic check_reset(string tag);
    logic [22:0] act;
    act = {bus.hsync, bus.vsync, bus.video_on, bus.frame_tick,
           bus.red, bus.green, bus.blue, bus.cell_x, bus.cell_y};
    tests++;
    if (act !== {4'b1100, 8'h00, 11'h000}) begin
      fails++;
      $display("FAIL %s got %h exp %h", tag, act,
               {4'b1100, 8'h00, 11'h000});
    end
  endtask

  task automatic hold_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.h_count   = 10'($urandom_range(0, 1023));
      bus.v_count   = 10'($urandom_range(0, 1023));
      bus.game_over = 1'($urandom);
      #2;
      check_reset("reset_hold");
    end
    @(negedge clk);
    bus.h_count = 10'd700;
    bus.v_count = 10'd1;
    rst  = 1'b0;
    fcnt = 0;
  endtask

  initial begin
    int h, v;
    bit go;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++)
        board[y][x] = 2'($urandom);
    board[6][6]  = 2'b10;
    board[12][0] = 2'b11;
    bus.h_count   = 10'd0;
    bus.v_count   = 10'd0;
    bus.game_over = 1'b0;

    hold_reset(6);

    for (int i = 0; i <= 800; i++)
      drive(i, 0, 0, 1);
    drain();
    tests++;
    if (hs_lows != 96) begin
      fails++;
      $display("FAIL hsync_width got %0d exp 96", hs_lows);
    end

    drive(100, 100, 0, 0);
    drive(5, 200, 0, 0);
    drive(700, 200, 0, 0);
    drive(100, 490, 0, 0);
    drive(100, 491, 1, 0);
    drive(639, 479, 0, 0);
    drive(640, 479, 0, 0);
    drive(805, 530, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);

    for (int f = 0; f < 64; f++) begin
      drive(0, 0, 1, 0);
      drive(0, 100, 1, 0);
      drive(100, 100, 1, 0);
    end
    drain();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        h = 0;
        v = 0;
      end else if ($urandom_range(0, 1) == 0) begin
        h = $urandom_range(0, 639);
        v = $urandom_range(0, 479);
      end else begin
        h = $urandom_range(0, 1023);
        v = $urandom_range(0, 1023);
      end
      go = 1'($urandom);
      drive(h, v, go, 0);
    end
    drain();

    // asynchronous reset between clock edges
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check_reset("reset_async");
    qa.delete();
    qo.delete();
    hold_reset(3);

    for (int f = 0; f < 20; f++) begin
      drive(0, 0, 1, 0);
      drive(639, 300, 1, 0);
      drive($urandom_range(16, 623), $urandom_range(16, 463), 1, 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
